// File: rtl/ahbl_led_pwm_pkg.sv
// Shared definitions for the AHB-Lite LED/PWM block: register word offsets, mode codes, HTRANS codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ahbl_led_pwm_pkg;

  // Register word indices, i.e. HADDR[7:2] (byte offset / 4)
  localparam logic [5:0] REG_OUT       = 6'h00;  // 0x00
  localparam logic [5:0] REG_MODE      = 6'h01;  // 0x04
  localparam logic [5:0] REG_PRESCALE  = 6'h02;  // 0x08
  localparam logic [5:0] REG_CTRL      = 6'h03;  // 0x0C
  localparam logic [5:0] REG_DUTY_BASE = 6'h04;  // 0x10 + 4*i

  // Per-channel output mode, two bits per channel in MODE
  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_OFF    = 2'b11
  } led_mode_e;

  // AHB-Lite transfer types; bit 1 set means a real transfer
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Address-phase information carried into the data phase
  typedef struct packed {
    logic       vld;
    logic       write;
    logic [5:0] addr;
  } ahb_dp_t;

  // Word index of DUTY register for channel ch
  function automatic logic [5:0] duty_index(input int ch);
    return REG_DUTY_BASE + 6'(ch);
  endfunction

endpackage

// File: rtl/ahbl_led_pwm_timebase.sv
// Shared LED timebase: prescaler dividing HCLK into ticks, and a free-running period counter.
// Latency: tick/wrap are combinational from current state; cnt advances on the edge that ends a tick cycle.
// Backpressure: none; disabling holds prescaler and counter at zero.
module led_pwm_timebase
  import ahbl_led_pwm_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PRE_W-1:0] prescale,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             wrap
);

  logic [PRE_W-1:0] pre;

  // Using >= rather than == lets a smaller PRESCALE written mid-count wrap on the very next cycle.
  assign tick = en && (pre >= prescale);
  assign wrap = tick && (cnt == '1);

  // Prescaler and period counter; both forced to zero while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      cnt <= '0;
    end else if (!en) begin
      pre <= '0;
      cnt <= '0;
    end else if (tick) begin
      pre <= '0;
      cnt <= cnt + CNT_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/ahbl_led_pwm.sv
// AHB-Lite slave driving NCH LEDs in static, blink, PWM or forced-off mode with shadowed duty.
// Latency: zero-wait bus; register write -> LED_out change is one cycle after the data phase ends.
// Backpressure: none; HREADYOUT is tied high and HRESP is always OKAY.
module ahbl_led_pwm
  import ahbl_led_pwm_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int CNT_W = 8,
  parameter int PRE_W = 16
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  input  logic           HSEL,
  input  logic [31:0]    HADDR,
  input  logic [1:0]     HTRANS,
  input  logic           HWRITE,
  input  logic [2:0]     HSIZE,
  input  logic [31:0]    HWDATA,
  input  logic           HREADY,
  output logic           HREADYOUT,
  output logic           HRESP,
  output logic [31:0]    HRDATA,
  output logic [NCH-1:0] LED_out
);

  ahb_dp_t                    dp;
  logic                       wr_en;

  logic [NCH-1:0]             out_q;
  logic [2*NCH-1:0]           mode_q;
  logic [PRE_W-1:0]           prescale_q;
  logic                       en_q;
  logic [NCH-1:0][CNT_W-1:0]  duty_q;
  logic [NCH-1:0][CNT_W-1:0]  shadow_q;

  logic [CNT_W-1:0]           cnt;
  logic                       tick;
  logic                       wrap;
  logic [NCH-1:0]             led_nxt;
  logic [31:0]                rdata;

  // Upper address bits, byte lanes, size and spare data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:8], HADDR[1:0], HSIZE, HWDATA, tick};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // Address phase: remember what the next data phase is about
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp <= '0;
    end else if (HREADY) begin
      dp.vld   <= HSEL & HTRANS[1];
      dp.write <= HWRITE;
      dp.addr  <= HADDR[7:2];
    end
  end

  assign wr_en = dp.vld & dp.write & HREADY;

  // Data phase write: commit HWDATA at the end of the data-phase cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      out_q      <= '0;
      mode_q     <= '0;
      prescale_q <= '0;
      en_q       <= 1'b0;
      duty_q     <= '0;
    end else if (wr_en) begin
      case (dp.addr)
        REG_OUT:      out_q      <= HWDATA[NCH-1:0];
        REG_MODE:     mode_q     <= HWDATA[2*NCH-1:0];
        REG_PRESCALE: prescale_q <= HWDATA[PRE_W-1:0];
        REG_CTRL:     en_q       <= HWDATA[0];
        default: begin
          for (int i = 0; i < NCH; i++) begin
            if (dp.addr == duty_index(i)) begin
              duty_q[i] <= HWDATA[CNT_W-1:0];
            end
          end
        end
      endcase
    end
  end

  // Data phase read: combinational from the latched address; unmapped and non-read cycles give 0
  always_comb begin
    rdata = '0;
    if (dp.vld && !dp.write) begin
      case (dp.addr)
        REG_OUT:      rdata = 32'(out_q);
        REG_MODE:     rdata = 32'(mode_q);
        REG_PRESCALE: rdata = 32'(prescale_q);
        REG_CTRL:     rdata = 32'(en_q);
        default: begin
          for (int i = 0; i < NCH; i++) begin
            if (dp.addr == duty_index(i)) begin
              rdata = 32'(duty_q[i]);
            end
          end
        end
      endcase
    end
  end

  assign HRDATA = rdata;

  led_pwm_timebase #(
    .CNT_W (CNT_W),
    .PRE_W (PRE_W)
  ) u_timebase (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .en       (en_q),
    .prescale (prescale_q),
    .cnt      (cnt),
    .tick     (tick),
    .wrap     (wrap)
  );

  // Shadow duty tracks DUTY while stopped, and only at period wrap while running, so a PWM period never
  // mixes two duty values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      shadow_q <= '0;
    end else if (!en_q || wrap) begin
      shadow_q <= duty_q;
    end
  end

  // Per-channel output select; mode changes take effect immediately
  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      case (led_mode_e'(mode_q[2*i +: 2]))
        MODE_STATIC: led_nxt[i] = out_q[i];
        MODE_BLINK:  led_nxt[i] = cnt[CNT_W-1];
        MODE_PWM:    led_nxt[i] = (cnt < shadow_q[i]);
        default:     led_nxt[i] = 1'b0;
      endcase
    end
  end

  // Registered LED drive keeps the pins glitch-free
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      LED_out <= '0;
    end else begin
      LED_out <= led_nxt;
    end
  end

endmodule

// File: tb/tb_ahbl_led_pwm.sv
// Self-checking bench for ahbl_led_pwm: directed bus traffic, a tick-counting reference model
// compared every cycle, and hand-computed literal expectations for pulse widths and register reads.
module tb_ahbl_led_pwm;

  localparam int NCH     = 3;
  localparam int CNT_W   = 8;
  localparam int PRE_W   = 16;
  localparam int CNT_MOD = 1 << CNT_W;

  logic           HCLK = 1'b0;
  logic           HRESETn = 1'b0;
  logic           HSEL = 1'b0;
  logic [31:0]    HADDR = '0;
  logic [1:0]     HTRANS = 2'b00;
  logic           HWRITE = 1'b0;
  logic [2:0]     HSIZE = 3'b010;
  logic [31:0]    HWDATA = '0;
  logic           HREADY = 1'b1;
  logic           HREADYOUT;
  logic           HRESP;
  logic [31:0]    HRDATA;
  logic [NCH-1:0] LED_out;

  ahbl_led_pwm #(.NCH(NCH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .LED_out   (LED_out)
  );

  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural register contents
  logic [NCH-1:0]   m_out;
  logic [2*NCH-1:0] m_mode;
  int               m_prescale;
  bit               m_en;
  int               m_duty[NCH];
  // Timebase as arithmetic: total ticks since enable, cycles since the last tick,
  // and the duty captured at the start of the current period.
  int               m_ticks;
  int               m_phase;
  int               m_period_duty[NCH];
  // Pending bus transfer
  bit               m_pv, m_pw;
  int               m_pa;
  logic [NCH-1:0]   exp_led = '0;
  logic [31:0]      exp_rdata = '0;

  function automatic logic [31:0] model_read(input int a);
    if (a == 0) return 32'(m_out);
    if (a == 1) return 32'(m_mode);
    if (a == 2) return 32'(m_prescale);
    if (a == 3) return 32'(m_en);
    if (a >= 4 && a < 4 + NCH) return 32'(m_duty[a-4]);
    return 32'h0;
  endfunction

  function automatic logic [NCH-1:0] model_led();
    logic [NCH-1:0] r;
    int pos;
    r   = '0;
    pos = m_ticks % CNT_MOD;
    for (int ch = 0; ch < NCH; ch++) begin
      case (m_mode[2*ch +: 2])
        2'b00:   r[ch] = m_out[ch];
        2'b01:   r[ch] = (pos >= CNT_MOD / 2);
        2'b10:   r[ch] = (pos < m_period_duty[ch]);
        default: r[ch] = 1'b0;
      endcase
    end
    return r;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_out = '0; m_mode = '0; m_prescale = 0; m_en = 0;
      m_ticks = 0; m_phase = 0;
      for (int ch = 0; ch < NCH; ch++) begin m_duty[ch] = 0; m_period_duty[ch] = 0; end
      m_pv = 0; m_pw = 0; m_pa = 0;
      exp_led = '0; exp_rdata = '0;
    end else begin
      // LED pins show the rule applied to the state just before this edge
      exp_led = model_led();
      // Time advances using the settings in force before this edge
      if (!m_en) begin
        m_ticks = 0; m_phase = 0;
        for (int ch = 0; ch < NCH; ch++) m_period_duty[ch] = m_duty[ch];
      end else if (m_phase >= m_prescale) begin
        m_phase = 0;
        if (m_ticks % CNT_MOD == CNT_MOD - 1)
          for (int ch = 0; ch < NCH; ch++) m_period_duty[ch] = m_duty[ch];
        m_ticks++;
      end else begin
        m_phase++;
      end
      // Write data phase completes at this edge
      if (m_pv && m_pw) begin
        if (m_pa == 0) m_out = HWDATA[NCH-1:0];
        else if (m_pa == 1) m_mode = HWDATA[2*NCH-1:0];
        else if (m_pa == 2) m_prescale = int'(HWDATA[PRE_W-1:0]);
        else if (m_pa == 3) m_en = HWDATA[0];
        else if (m_pa >= 4 && m_pa < 4 + NCH) m_duty[m_pa-4] = int'(HWDATA[CNT_W-1:0]);
      end
      // New address phase
      m_pv = HSEL && HREADY && HTRANS[1];
      m_pw = HWRITE;
      m_pa = int'(HADDR[7:2]);
      exp_rdata = model_read(m_pa);
    end
  end

  // Single compare process, sampled mid-cycle
  always @(negedge HCLK) begin
    if (chk_on) begin
      check("led_out", 32'(LED_out), 32'(exp_led));
      check("hreadyout", 32'(HREADYOUT), 32'd1);
      check("hresp", 32'(HRESP), 32'd0);
      if (HRESETn && m_pv && !m_pw) check("hrdata", HRDATA, exp_rdata);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = {24'h0, a};
    @(negedge HCLK);
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
    @(negedge HCLK);
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = {24'h0, a};
    @(negedge HCLK);
    HSEL = 0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic ahb_write_read(input logic [7:0] a, input logic [31:0] wd, output logic [31:0] rd);
    @(negedge HCLK);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = {24'h0, a};
    @(negedge HCLK);
    HWDATA = wd; HWRITE = 0; HTRANS = 2'b11;
    @(negedge HCLK);
    HSEL = 0; HTRANS = 2'b00;
    rd = HRDATA;
  endtask

  task automatic wait_level(input int ch, input bit lvl, input int budget, input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge HCLK);
      if (LED_out[ch] == lvl) begin ok = 1; break; end
    end
    if (!ok) check(name, 32'(LED_out[ch]), 32'(lvl));
  endtask

  task automatic measure_run(input int ch, input bit lvl, input int budget, output int len);
    len = 0;
    while (LED_out[ch] == lvl && len < budget) begin
      @(negedge HCLK);
      len++;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] rd;
    int len;

    repeat (3) @(negedge HCLK);
    chk_on = 1'b1;
    HRESETn = 1'b1;

    // 1: reset state of every register
    for (int a = 0; a <= 8'h18; a += 4) begin
      ahb_read(8'(a), rd);
      check("reset_read", rd, 32'h0);
    end
    check("reset_led", 32'(LED_out), 32'h0);

    // 2: static outputs, one-cycle LED latency after commit
    ahb_write(8'h00, 32'h5);
    check("static_latency_0", 32'(LED_out), 32'h0);
    @(negedge HCLK);
    check("static_led", 32'(LED_out), 32'h5);
    ahb_read(8'h00, rd);
    check("read_out", rd, 32'h5);
    ahb_write_read(8'h08, 32'h1234, rd);
    check("b2b_write_read", rd, 32'h1234);

    // 3: PWM duty 64 with prescale 0, then duty change mid-period
    ahb_write(8'h08, 32'h0);
    ahb_write(8'h10, 32'd64);
    ahb_write(8'h04, 32'h2);
    ahb_write(8'h0C, 32'h1);
    wait_level(0, 1'b0, 600, "pwm_wait_low");
    wait_level(0, 1'b1, 600, "pwm_wait_high");
    measure_run(0, 1'b1, 600, len);
    check("pwm64_high", 32'(len), 32'd64);
    ahb_write(8'h10, 32'd192);
    ahb_read(8'h10, rd);
    check("duty_readback", rd, 32'd192);
    wait_level(0, 1'b1, 600, "pwm192_wait_high");
    measure_run(0, 1'b1, 600, len);
    check("pwm192_high", 32'(len), 32'd192);
    measure_run(0, 1'b0, 600, len);
    check("pwm192_low", 32'(len), 32'd64);

    // 4: blink on ch1 with prescale 3 (written while running)
    ahb_write(8'h08, 32'h3);
    ahb_write(8'h04, 32'h6);
    wait_level(1, 1'b0, 1200, "blink_wait_low");
    wait_level(1, 1'b1, 1200, "blink_wait_high");
    measure_run(1, 1'b1, 1200, len);
    check("blink_high", 32'(len), 32'd512);
    measure_run(1, 1'b0, 1200, len);
    check("blink_low", 32'(len), 32'd512);

    // 5: ch2 PWM with duty 0, then disable mid-period
    ahb_write(8'h04, 32'h26);
    repeat (37) @(negedge HCLK);
    ahb_write(8'h0C, 32'h0);
    repeat (3) @(negedge HCLK);
    check("disabled_led", 32'(LED_out), 32'h1);
    repeat (20) @(negedge HCLK);
    check("disabled_hold", 32'(LED_out), 32'h1);

    // 6: asynchronous reset during an in-flight write
    @(negedge HCLK);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h0;
    @(negedge HCLK);
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = 32'h7;
    #2 HRESETn = 1'b0;
    #1 check("async_reset_led", 32'(LED_out), 32'h0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int a = 0; a <= 8'h18; a += 4) begin
      ahb_read(8'(a), rd);
      check("post_reset_read", rd, 32'h0);
    end
    ahb_write(8'h40, 32'hFFFF_FFFF);
    ahb_read(8'h40, rd);
    check("unmapped_read", rd, 32'h0);
    ahb_read(8'h00, rd);
    check("unmapped_no_alias", rd, 32'h0);
    repeat (4) @(negedge HCLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
